// File: rtl/vec_magnitude_isqrt.sv
// 2-D vector magnitude: floor(sqrt(x*x + y*y)) using an exact bit-serial integer square root.
// Valid/ready handshake on both sides; one operand pair in flight at a time.
module vec_magnitude_isqrt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W:0]   mag,
  output logic         exact,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int SW = 2 * W + 1;  // sum / remainder width
  localparam int RW = 2 * W + 2;  // root and trial width, wide enough for root + bit
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SQRT,
    DONE
  } state_t;

  state_t        state_q;
  logic [W-1:0]  x_q;
  logic [W-1:0]  y_q;
  logic [SW-1:0] rem_q;
  logic [SW-1:0] rem_d;
  logic [RW-1:0] root_q;
  logic [RW-1:0] root_d;
  logic [RW-1:0] bit_q;
  logic [RW-1:0] trial;
  logic [CW-1:0] cnt_q;
  logic [W:0]    mag_q;
  logic          exact_q;
  logic          out_valid_q;

  logic [2*W-1:0] sq_x;
  logic [2*W-1:0] sq_y;
  logic [SW-1:0]  sum;

  // Squares are formed at full width so x = y = 2^W-1 cannot wrap.
  assign sq_x  = {{W{1'b0}}, x_q} * {{W{1'b0}}, x_q};
  assign sq_y  = {{W{1'b0}}, y_q} * {{W{1'b0}}, y_q};
  assign sum   = {1'b0, sq_x} + {1'b0, sq_y};
  assign trial = root_q + bit_q;

  // One restoring square-root step; the FSM decides whether to commit it.
  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rem_d  = rem_q;
    root_d = root_q >> 1;
    if ({1'b0, rem_q} >= trial) begin
      rem_d  = rem_q - trial[SW-1:0];
      root_d = (root_q >> 1) + bit_q;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values, matching the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      mag_q       <= '0;
      exact_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ena && in_valid) begin
            x_q     <= in_x;
            y_q     <= in_y;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (ena) begin
            rem_q   <= sum;
            root_q  <= '0;
            bit_q   <= {{(RW - SW){1'b0}}, 1'b1, {(2 * W){1'b0}}};
            cnt_q   <= CW'(W);
            state_q <= SQRT;
          end
        end
        SQRT: begin
          if (ena) begin
            rem_q  <= rem_d;
            root_q <= root_d;
            bit_q  <= bit_q >> 2;
            if (cnt_q == '0) begin
              mag_q       <= root_d[W:0];
              exact_q     <= (rem_d == '0);
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
        DONE: begin
          // Result hand-off is independent of ena so a stalled core never blocks the consumer.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = ena && (state_q == IDLE);
  assign mag       = mag_q;
  assign exact     = exact_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_vec_magnitude_isqrt.sv
// Self-checking bench for vec_magnitude_isqrt (W=8): directed scenarios plus a randomised
// scoreboard run against an independent floor-sqrt reference.
module tb_vec_magnitude_isqrt;

  localparam int W = 8;

  typedef struct packed {
    logic [W:0] mag;
    logic       exact;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic         in_valid;
  logic         in_ready;
  logic [W:0]   mag;
  logic         exact;
  logic         out_valid;
  logic         out_ready;

  int   checks   = 0;
  int   failures = 0;
  res_t exp_q[$];

  vec_magnitude_isqrt #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .in_x     (in_x),
    .in_y     (in_y),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mag      (mag),
    .exact    (exact),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Reference: linear search for the largest r with r*r <= x*x + y*y.
  function automatic res_t ref_res(input logic [W-1:0] x, input logic [W-1:0] y);
    int   s;
    int   r;
    res_t res;
    s = int'(x) * int'(x) + int'(y) * int'(y);
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    res.mag   = r[W:0];
    res.exact = (r * r == s);
    return res;
  endfunction

  // Full transaction from IDLE: accept, optional ena stall, optional output backpressure, hand-off.
  task automatic do_txn(input logic [W-1:0] x, input logic [W-1:0] y, input int exp_lat,
                        input int stall_at, input int stall_len, input int hold, input string name);
    res_t       exp_r;
    int         e;
    bit         bad_busy;
    bit         bad_hold;
    logic [W:0] held;
    @(negedge clk);
    ena = 1'b1; out_ready = 1'b0;
    in_x = x; in_y = y; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_accept: in_ready=%b required=1", name, in_ready);
    end
    exp_q.push_back(ref_res(x, y));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_x = ~x; in_y = x ^ y;
    e = 0; bad_busy = 1'b0;
    forever begin
      #1;
      if (out_valid === 1'b1 || e >= 100) break;
      ena = !(e >= stall_at && e < stall_at + stall_len);
      #1;
      if (in_ready !== 1'b0) bad_busy = 1'b1;
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    ena = 1'b1;
    checks++;
    if (e != exp_lat) begin
      failures++;
      $display("FAIL %s_latency: edges=%0d required=%0d", name, e, exp_lat);
    end
    checks++;
    if (bad_busy) begin
      failures++;
      $display("FAIL %s_busy_in_ready: in_ready=1 while computing required=0", name);
    end
    held = mag; bad_hold = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      if (out_valid !== 1'b1 || mag !== held || in_ready !== 1'b0) bad_hold = 1'b1;
    end
    checks++;
    if (bad_hold) begin
      failures++;
      $display("FAIL %s_backpressure: out_valid=%b mag=%0d in_ready=%b required 1/%0d/0",
               name, out_valid, mag, in_ready, held);
    end
    exp_r = exp_q.pop_front();
    checks++;
    if (mag !== exp_r.mag) begin
      failures++;
      $display("FAIL %s_mag: got=%0d required=%0d", name, mag, exp_r.mag);
    end
    checks++;
    if (exact !== exp_r.exact) begin
      failures++;
      $display("FAIL %s_exact: got=%b required=%b", name, exact, exp_r.exact);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_handoff: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_y = '0;
    #3;
    checks++;
    if (out_valid !== 1'b0 || mag !== '0 || exact !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: out_valid=%b mag=%0d exact=%b required 0/0/0", out_valid, mag, exact);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    do_txn(8'd3, 8'd4, 10, 1000, 0, 0, "basic_3_4");
  endtask

  task automatic test_corners();
    do_txn(8'd255, 8'd255, 10, 1000, 0, 0, "max_255_255");
    do_txn(8'd0,   8'd0,   10, 1000, 0, 0, "zero_0_0");
    do_txn(8'd1,   8'd1,   10, 1000, 0, 0, "one_1_1");
    do_txn(8'd0,   8'd255, 10, 1000, 0, 0, "axis_0_255");
  endtask

  task automatic test_backpressure();
    do_txn(8'd7, 8'd24, 10, 1000, 0, 20, "bp_7_24");
  endtask

  task automatic test_ena_stall();
    do_txn(8'd6, 8'd8, 15, 4, 5, 0, "stall_6_8");
  endtask

  task automatic test_mid_reset();
    bit seen;
    @(negedge clk);
    ena = 1'b1; in_x = 8'd9; in_y = 8'd9; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || mag !== '0) begin
      failures++;
      $display("FAIL midreset_clear: out_valid=%b mag=%0d required 0/0", out_valid, mag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_in_ready: in_ready=%b required=1", in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midreset_no_partial: out_valid=1 after abandoned operation required=0");
    end
    do_txn(8'd5, 8'd12, 10, 1000, 0, 0, "post_reset_5_12");
  endtask

  task automatic test_random(input int n);
    int   sent;
    int   recv;
    int   cyc;
    res_t exp_r;
    sent = 0; recv = 0; cyc = 0;
    @(negedge clk);
    while ((sent < n || recv < sent) && cyc < 60000) begin
      ena       = ($urandom_range(0, 9) != 0);
      in_valid  = (sent < n) && ($urandom_range(0, 1) == 1);
      in_x      = W'($urandom);
      in_y      = W'($urandom);
      if ($urandom_range(0, 15) == 0) in_x = '1;
      if ($urandom_range(0, 15) == 0) in_y = '0;
      out_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_res(in_x, in_y));
        sent++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_duplicate: result %0d with empty scoreboard", recv);
        end else begin
          exp_r = exp_q.pop_front();
          if (mag !== exp_r.mag || exact !== exp_r.exact) begin
            failures++;
            $display("FAIL rand_result_%0d: mag=%0d exact=%b required mag=%0d exact=%b",
                     recv, mag, exact, exp_r.mag, exp_r.exact);
          end
        end
        recv++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (recv != n || sent != n || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rand_count: sent=%0d received=%0d pending=%0d required %0d/%0d/0",
               sent, recv, exp_q.size(), n, n);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_ena_stall();
    test_mid_reset();
    test_random(1000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
